data_port_arbiter: RTL and testbench

Shares the data port (port B) of the main BlockRam between two requesters: requester 0 is the CPU memory controller's data side, requester 1 is a peripheral/DMA engine (LCD text fetcher, later others). It runs a registered round-robin arbiter that drives the RAM port from registers and returns read data with a one-cycle `rvalid` pulse. It sits between `MemoryController`/peripherals and `MainMemory` port B; instruction port A is untouched.

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_pick2.sv | 20 ++
 rtl/data_port_arbiter.sv | 128 ++++++++++++
 tb/tb_data_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-map constants and arbiter state encoding for the BlockRam data port.
package mem_pkg;

   localparam int unsigned MEM_WORDS  = 12288;
   localparam int unsigned RAM_ADDR_W = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_e;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester not granted last wins.
module rr_pick2 (
   input  logic [1:0] eligible,
   input  logic       last,
   output logic       grant_valid_c,
   output logic       grant_idx_c
);

   always_comb begin
      grant_valid_c = |eligible;
      grant_idx_c   = 1'b0;
      case (eligible)
         2'b01:   grant_idx_c = 1'b0;
         2'b10:   grant_idx_c = 1'b1;
         2'b11:   grant_idx_c = ~last;
         default: grant_idx_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/data_port_arbiter.sv
// Registered round-robin arbiter sharing BlockRam port B between the CPU data side
// (requester 0) and a peripheral/DMA engine (requester 1).
module data_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic                  CLK_50MHZ,
   input  logic                  reset,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic [DATA_W-1:0]     wdata1,
   output logic [1:0]            gnt,
   output logic [1:0]            rvalid,
   output logic [1:0]            err,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata
);

   arb_state_e              state_q, state_d;
   logic                    last_q, last_d;
   logic [1:0]              gnt_q, gnt_d;
   logic                    ram_we_q, ram_we_d;
   logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]       ram_wdata_q, ram_wdata_d;
   logic                    rd_q, rd_d;
   logic                    oor_q, oor_d;
   logic [1:0]              rvalid_q, rvalid_d;
   logic [1:0]              err_q, err_d;
   logic                    rsel_q, rsel_d;

   logic [1:0]              eligible_c;
   logic                    pick_valid_c;
   logic                    pick_idx_c;
   logic [ADDR_W-1:0]       sel_addr_c;
   logic [DATA_W-1:0]       sel_wdata_c;
   logic                    sel_we_c;
   logic                    in_range_c;

   // The requester granted last cycle still shows its old request, so mask it.
   always_comb begin
      eligible_c[0] = req[0] && (state_q != G0);
      eligible_c[1] = req[1] && (state_q != G1);
   end

   rr_pick2 u_pick (
      .eligible      (eligible_c),
      .last          (last_q),
      .grant_valid_c (pick_valid_c),
      .grant_idx_c   (pick_idx_c)
   );

   always_comb begin
      sel_addr_c  = pick_idx_c ? addr1  : addr0;
      sel_wdata_c = pick_idx_c ? wdata1 : wdata0;
      sel_we_c    = we[pick_idx_c];
      in_range_c  = 32'(sel_addr_c) < MEM_WORDS;
   end

   always_comb begin
      state_d     = IDLE;
      last_d      = last_q;
      gnt_d       = 2'b00;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rd_d        = 1'b0;
      oor_d       = 1'b0;
      // Response stage: one cycle behind the grant, aligned with RAM read latency.
      rvalid_d    = rd_q  ? gnt_q : 2'b00;
      err_d       = oor_q ? gnt_q : 2'b00;
      rsel_d      = rd_q & ~oor_q;
      if (pick_valid_c) begin
         state_d     = pick_idx_c ? G1 : G0;
         last_d      = pick_idx_c;
         gnt_d       = onehot2(pick_idx_c);
         ram_we_d    = sel_we_c & in_range_c;
         ram_addr_d  = sel_addr_c[RAM_ADDR_W-1:0];
         ram_wdata_d = sel_wdata_c;
         rd_d        = ~sel_we_c;
         oor_d       = ~in_range_c;
      end
   end

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt_q       <= 2'b00;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_q        <= 1'b0;
         oor_q       <= 1'b0;
         rvalid_q    <= 2'b00;
         err_q       <= 2'b00;
         rsel_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rd_q        <= rd_d;
         oor_q       <= oor_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
         rsel_q      <= rsel_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign err       = err_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign rdata     = rsel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a BlockRam model and a response scoreboard.
module tb_data_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        mem_clr_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [15:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [1:0]  gnt, rvalid, err;
   logic [15:0] rdata;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   typedef struct {
      int          due;
      logic        idx;
      logic        rd;
      logic        oor;
      logic [15:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] shadow[int];
   int          total;
   int          bad;
   int          cyc_n;
   int          gcount[2];
   logic        auto_drop;
   logic        in_rst;
   int          lat;

   logic [15:0] ram_mem [0:16383];
   logic [16383:0] ram_vld;

   data_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .CLK_50MHZ (clk),
      .reset     (rst_n),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .err       (err),
      .rdata     (rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input logic [13:0] a);
      return {2'b10, a} ^ 16'h5A5A;
   endfunction

   // BlockRam port B model: synchronous read, read-before-write.
   always @(posedge clk or negedge mem_clr_n) begin
      if (!mem_clr_n) begin
         ram_vld   <= '0;
         ram_rdata <= '0;
      end else begin
         ram_rdata <= ram_vld[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_vld[ram_addr] <= 1'b1;
         end
      end
   end

   function automatic logic [1:0] oh(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [15:0] exp_mem(input logic [15:0] a);
      return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a[13:0]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t        e;
      logic [15:0] a, d;
      logic        w, inr;
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
         e = sbq.pop_front();
         chk("rvalid", 32'(rvalid), e.rd  ? 32'(oh(e.idx)) : 32'd0);
         chk("err",    32'(err),    e.oor ? 32'(oh(e.idx)) : 32'd0);
         if (e.rd) chk("rdata", 32'(rdata), 32'(e.data));
      end else begin
         chk("no_resp", 32'({rvalid, err}), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) begin
            a   = (i == 0) ? addr0  : addr1;
            d   = (i == 0) ? wdata0 : wdata1;
            w   = we[i];
            inr = 32'(a) < 32'd12288;
            chk("gnt_had_req", 32'(req[i]), 32'd1);
            chk("ram_we",   32'(ram_we),   32'(w & inr));
            chk("ram_addr", 32'(ram_addr), 32'(a[13:0]));
            if (w) chk("ram_wdata", 32'(ram_wdata), 32'(d));
            if (w && inr) shadow[int'(a)] = d;
            if (!w || !inr) begin
               e.due  = cyc_n + 1;
               e.idx  = 1'(i);
               e.rd   = !w;
               e.oor  = !inr;
               e.data = (!w && inr) ? exp_mem(a) : 16'h0000;
               sbq.push_back(e);
            end
            gcount[i]++;
            if (auto_drop) req[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (!in_rst) monitor();
   endtask

   task automatic access(input int i, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int l);
      logic got;
      got       = 1'b0;
      l         = 0;
      auto_drop = 1'b1;
      if (i == 0) begin addr0 = a; wdata0 = d; end
      else        begin addr1 = a; wdata1 = d; end
      we[i]  = w;
      req[i] = 1'b1;
      for (int k = 0; k < 8 && !got; k++) begin
         cyc();
         l++;
         if (gnt[i]) got = 1'b1;
      end
      if (!got) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         req[i] = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt),       32'd0);
      chk({tag, "_rv"},    32'(rvalid),    32'd0);
      chk({tag, "_err"},   32'(err),       32'd0);
      chk({tag, "_we"},    32'(ram_we),    32'd0);
      chk({tag, "_addr"},  32'(ram_addr),  32'd0);
      chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
      chk({tag, "_rdata"}, 32'(rdata),     32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; cyc_n = 0;
      gcount[0] = 0; gcount[1] = 0;
      auto_drop = 1'b1; in_rst = 1'b1;
      rst_n = 1'b0; mem_clr_n = 1'b0;
      req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset values
      cyc(); cyc();
      mem_clr_n = 1'b1;
      cyc();
      chk_all_zero("reset");
      rst_n = 1'b1; in_rst = 1'b0;
      cyc();

      // Write then read back on requester 0
      access(0, 1'b1, 16'h0010, 16'hBEEF, lat);
      chk("wr_latency", 32'(lat), 32'd1);
      cyc(); cyc();
      access(0, 1'b0, 16'h0010, 16'h0000, lat);
      chk("rd_latency", 32'(lat), 32'd1);
      cyc(); cyc();

      // Out-of-range read
      access(0, 1'b0, 16'h3000, 16'h0000, lat);
      chk("oor_rd_latency", 32'(lat), 32'd1);
      cyc(); cyc();

      // Out-of-range write on requester 1, then read the aliasing-safe word
      access(1, 1'b1, 16'h3FFF, 16'h1234, lat);
      chk("oor_wr_latency", 32'(lat), 32'd1);
      cyc(); cyc();
      access(0, 1'b0, 16'h0FFF, 16'h0000, lat);
      cyc(); cyc();

      // Requester 1 alone, held for 6 cycles
      auto_drop = 1'b0;
      gcount[1] = 0;
      we[1] = 1'b0; addr1 = 16'h0020; req = 2'b10;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("solo_gnt", 32'(gnt), (k % 2 == 0) ? 32'd2 : 32'd0);
      end
      req = 2'b00;
      chk("solo_count", 32'(gcount[1]), 32'd3);
      cyc(); cyc();

      // Both requesters reading continuously
      we = 2'b00; addr0 = 16'h0010; addr1 = 16'h0FFF; req = 2'b11;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("alt_gnt", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req = 2'b00;
      cyc(); cyc();
      chk("sb_empty_mid", 32'(sbq.size()), 32'd0);

      // Reset asserted while a read is in flight
      access(0, 1'b0, 16'h0010, 16'h0000, lat);
      rst_n = 1'b0; in_rst = 1'b1;
      sbq.delete();
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_all_zero("midrst");
      end
      rst_n = 1'b1; in_rst = 1'b0;
      auto_drop = 1'b1;
      we = 2'b00; addr0 = 16'h0010; addr1 = 16'h0FFF; req = 2'b11;
      cyc();
      chk("post_rst_first", 32'(gnt), 32'd1);
      for (int k = 0; k < 6 && req != 2'b00; k++) cyc();
      chk("post_rst_drained", 32'(req), 32'd0);
      cyc(); cyc();
      chk("sb_empty_end", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
